// File: rtl/ostar_accum.sv
// Running output accumulator: o_star = sat(exp_o + exp_v) per element,
// fed back to expmul, with a one-deep ready/valid buffer for finished rows.
module ostar_accum #(
    parameter int DIM   = 4,
    parameter int W     = 27,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld_in,
    output logic               rdy_out,
    input  logic [DIM*W-1:0]   exp_v_in,
    input  logic [DIM*W-1:0]   exp_o_in,
    input  logic               last_in,
    output logic [DIM*W-1:0]   o_star_prev_out,
    output logic               vld_out,
    input  logic               rdy_in,
    output logic [DIM*W-1:0]   o_star_out,
    output logic [CNT_W-1:0]   key_cnt_out
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [DIM*W-1:0]   acc_q, acc_d;
    logic [DIM*W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   kcnt_q, kcnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DIM*W-1:0]   sum;
    logic               in_fire;
    logic               out_fire;
    logic               last_fire;

    // Sign-extend to W+1 bits; overflow shows as the top two bits differing.
    for (genvar i = 0; i < DIM; i++) begin : g_sat
        logic [W:0] s;
        assign s = {exp_o_in[i*W+W-1], exp_o_in[i*W +: W]}
                 + {exp_v_in[i*W+W-1], exp_v_in[i*W +: W]};
        assign sum[i*W +: W] = (s[W] == s[W-1]) ? s[W-1:0]
                             : (s[W] ? SAT_MIN : SAT_MAX);
    end

    assign vld_out         = (state_q == FULL);
    assign rdy_out         = !(vld_out && !rdy_in);
    assign in_fire         = vld_in && rdy_out;
    assign out_fire        = vld_out && rdy_in;
    assign last_fire       = in_fire && last_in;
    assign cnt_inc         = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign o_star_prev_out = acc_q;
    assign o_star_out      = out_q;
    assign key_cnt_out     = kcnt_q;

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        kcnt_d = kcnt_q;
        if (in_fire) begin
            if (last_in) begin
                out_d  = sum;
                kcnt_d = cnt_inc;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d  = sum;
                cnt_d  = cnt_inc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (last_fire) state_d = FULL;
            FULL:  if (out_fire && !last_fire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            kcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            kcnt_q  <= kcnt_d;
        end
    end

endmodule
